// File: rtl/spell_pkg.sv
// rtl/spell_pkg.sv - shared state encoding, requester ids and request fields for spell_mem_arbiter
package spell_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       type_data;
    logic       write;
  } req_fields_t;

endpackage

// File: rtl/spell_mem_arbiter_if.sv
// rtl/spell_mem_arbiter_if.sv - requester and spell_mem bus bundle for spell_mem_arbiter
interface spell_mem_arbiter_if;

  logic       cpu_req;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_type_data;
  logic       cpu_write;
  logic       cpu_ack;

  logic       dbg_req;
  logic [7:0] dbg_addr;
  logic [7:0] dbg_wdata;
  logic       dbg_type_data;
  logic       dbg_write;
  logic       dbg_ack;

  logic [7:0] rdata;
  logic       err;

  logic       mem_select;
  logic [7:0] mem_addr;
  logic [7:0] mem_data_in;
  logic       mem_type_data;
  logic       mem_write;
  logic [7:0] mem_data_out;
  logic       mem_data_ready;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_type_data, cpu_write,
    input  dbg_req, dbg_addr, dbg_wdata, dbg_type_data, dbg_write,
    output cpu_ack, dbg_ack, rdata, err,
    output mem_select, mem_addr, mem_data_in, mem_type_data, mem_write,
    input  mem_data_out, mem_data_ready
  );

  // Requesters plus memory, i.e. everything around the arbiter
  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_type_data, cpu_write,
    output dbg_req, dbg_addr, dbg_wdata, dbg_type_data, dbg_write,
    input  cpu_ack, dbg_ack, rdata, err,
    input  mem_select, mem_addr, mem_data_in, mem_type_data, mem_write,
    output mem_data_out, mem_data_ready
  );

endinterface

// File: rtl/spell_rr_arb2.sv
// rtl/spell_rr_arb2.sv - combinational two-way round-robin pick (req[0]=CPU, req[1]=debug)
module spell_rr_arb2
  import spell_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  // On a tie the requester that was not served last wins; with no request the output is don't-care.
  always_comb begin
    grant = REQ_CPU;
    if (req == 2'b11) begin
      grant = ~last;
    end else if (req[1]) begin
      grant = REQ_DBG;
    end
  end

endmodule

// File: rtl/spell_mem_arbiter.sv
// rtl/spell_mem_arbiter.sv - single-port spell_mem arbiter for CPU and debug host
// Optional BUSY timeout abort enabled by SPELL_MEM_ARB_TIMEOUT_EN.
module spell_mem_arbiter
  import spell_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  spell_mem_arbiter_if.slave  bus
);

  arb_state_t  state;
  arb_state_t  state_nxt;
  logic        grant_id;
  logic        last_grant;
  logic        pick;
  logic        any_req;
  logic        busy;
  logic        abort;
  req_fields_t req_q;
  req_fields_t req_sel;
  logic [7:0]  rdata_q;

  assign any_req = bus.cpu_req | bus.dbg_req;
  assign busy    = (state == ARB_BUSY);

  spell_rr_arb2 u_rr (
    .req   ({bus.dbg_req, bus.cpu_req}),
    .last  (last_grant),
    .grant (pick)
  );

  always_comb begin
    req_sel = '{addr: bus.cpu_addr, wdata: bus.cpu_wdata,
                type_data: bus.cpu_type_data, write: bus.cpu_write};
    if (pick == REQ_DBG) begin
      req_sel = '{addr: bus.dbg_addr, wdata: bus.dbg_wdata,
                  type_data: bus.dbg_type_data, write: bus.dbg_write};
    end
  end

`ifdef SPELL_MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmr;
  logic          err_q;

  // tmr holds the number of BUSY cycles already completed, so the abort lands on the last allowed one.
  assign abort = busy && !bus.mem_data_ready && (tmr == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr   <= '0;
      err_q <= 1'b0;
    end else if (state == ARB_IDLE) begin
      tmr   <= '0;
      err_q <= 1'b0;
    end else if (busy) begin
      tmr   <= tmr + TW'(1);
      err_q <= abort;
    end
  end

  assign bus.err = (state == ARB_DONE) && err_q;
`else
  assign abort   = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE: if (any_req) state_nxt = ARB_BUSY;
      ARB_BUSY: if (bus.mem_data_ready || abort) state_nxt = ARB_DONE;
      ARB_DONE: state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_id   <= REQ_CPU;
      last_grant <= REQ_DBG;
      req_q      <= '0;
      rdata_q    <= '0;
    end else begin
      if (state == ARB_IDLE && any_req) begin
        grant_id <= pick;
        req_q    <= req_sel;
      end
      if (busy) begin
        if (abort) begin
          rdata_q <= 8'hFF;
        end else if (bus.mem_data_ready && !req_q.write) begin
          rdata_q <= bus.mem_data_out;
        end
      end
      if (state == ARB_DONE) begin
        last_grant <= grant_id;
      end
    end
  end

  // Memory-side outputs are forced to zero outside BUSY so idle/reset presents a quiet bus.
  assign bus.mem_select    = busy;
  assign bus.mem_addr      = busy ? req_q.addr      : 8'h00;
  assign bus.mem_data_in   = busy ? req_q.wdata     : 8'h00;
  assign bus.mem_type_data = busy ? req_q.type_data : 1'b0;
  assign bus.mem_write     = busy ? req_q.write     : 1'b0;

  assign bus.cpu_ack = (state == ARB_DONE) && (grant_id == REQ_CPU);
  assign bus.dbg_ack = (state == ARB_DONE) && (grant_id == REQ_DBG);
  assign bus.rdata   = rdata_q;

endmodule
